// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. It computes (a - b) mod 2^WIDTH one bit
//   per clock, LSB first, using a registered borrow. A start/done handshake
//   frames each operation.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   request; accepted only in IDLE or DONE
//   a, b    minuend / subtrahend, captured on an accepted start
//   diff    result, valid from done and held until the next done
//   borrow  final borrow, 1 iff a < b; same validity as diff
//   done    one-cycle pulse marking a new result
//   busy    high while the subtraction is in progress (RUN)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa, sb, sd;
    logic [WIDTH-1:0] sd_next;
    logic             br, br_next;
    logic             d;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             load;

    // One full-subtractor bit slice plus the result shift-in. The shift is
    // written as shift-then-insert so that WIDTH=1 needs no special case.
    always_comb begin
        d        = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sd_next  = sd >> 1;
        sd_next[WIDTH-1] = d;
        last_bit = (cnt == CW'(WIDTH - 1));
        load     = start && ((state == IDLE) || (state == DONE));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done are flops loaded from the next state so that they are true
    // registered outputs yet track the state they describe exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= sd_next;
            br  <= br_next;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                diff   <= sd_next;
                borrow <= br_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk;
    logic rst;

    logic        start8, start1, start32;
    logic [7:0]  a8, b8, diff8;
    logic [0:0]  a1, b1, diff1;
    logic [31:0] a32, b32, diff32;
    logic        borrow8, done8, busy8;
    logic        borrow1, done1, busy1;
    logic        borrow32, done32, busy32;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .borrow(borrow8), .done(done8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .diff(diff1), .borrow(borrow1), .done(done1), .busy(busy1)
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .diff(diff32), .borrow(borrow32), .done(done32), .busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // WIDTH=8 operation with full timing check: busy for 8 cycles, then one done.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
        @(negedge clk);
        start8 = 1'b1; a8 = av; b8 = bv;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        for (int i = 0; i < 8; i++) begin
            check("w8_busy_run", {63'd0, busy8}, 64'd1);
            check("w8_done_run", {63'd0, done8}, 64'd0);
            @(negedge clk);
        end
        check("w8_done", {63'd0, done8}, 64'd1);
        check("w8_busy_done", {63'd0, busy8}, 64'd0);
        check("w8_diff", {56'd0, diff8}, {56'd0, ed});
        check("w8_borrow", {63'd0, borrow8}, {63'd0, eb});
        @(negedge clk);
        check("w8_done_pulse", {63'd0, done8}, 64'd0);
        check("w8_diff_hold", {56'd0, diff8}, {56'd0, ed});
    endtask

    task automatic op1(input logic av, input logic bv);
        logic [1:0] e;
        e = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        start1 = 1'b1; a1 = av; b1 = bv;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", {63'd0, busy1}, 64'd1);
        @(negedge clk);
        check("w1_done", {63'd0, done1}, 64'd1);
        check("w1_diff", {63'd0, diff1}, {63'd0, e[0]});
        check("w1_borrow", {63'd0, borrow1}, {63'd0, e[1]});
    endtask

    task automatic op32(input logic [31:0] av, input logic [31:0] bv);
        logic [32:0] e;
        e = {1'b0, av} - {1'b0, bv};
        @(negedge clk);
        start32 = 1'b1; a32 = av; b32 = bv;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 32; i++) @(negedge clk);
        check("w32_done", {63'd0, done32}, 64'd1);
        check("w32_diff", {32'd0, diff32}, {32'd0, e[31:0]});
        check("w32_borrow", {63'd0, borrow32}, {63'd0, e[32]});
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; start1 = 1'b0; start32 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0; a32 = '0; b32 = '0;
        repeat (3) @(negedge clk);
        check("rst_diff8", {56'd0, diff8}, 64'd0);
        check("rst_borrow8", {63'd0, borrow8}, 64'd0);
        check("rst_done8", {63'd0, done8}, 64'd0);
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_busy1", {63'd0, busy1}, 64'd0);
        check("rst_busy32", {63'd0, busy32}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic directed vectors.
        op8(8'd5, 8'd3, 8'h02, 1'b0);
        op8(8'd3, 8'd5, 8'hFE, 1'b1);
        op8(8'h00, 8'hFF, 8'h01, 1'b1);
        op8(8'h00, 8'h00, 8'h00, 1'b0);
        op8(8'hFF, 8'h00, 8'hFF, 1'b0);
        op8(8'hA5, 8'h5A, 8'h4B, 1'b0);

        // start during RUN is ignored.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("ign_busy", {63'd0, busy8}, 64'd1);
            if (i == 2) begin
                start8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        check("ign_done", {63'd0, done8}, 64'd1);
        check("ign_diff", {56'd0, diff8}, 64'h7F);
        check("ign_borrow", {63'd0, borrow8}, 64'd0);
        @(negedge clk);
        check("ign_no_second_busy", {63'd0, busy8}, 64'd0);
        check("ign_no_second_done", {63'd0, done8}, 64'd0);

        // Reset mid-RUN aborts; reset also dominates a simultaneous start.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        check("abort_diff", {56'd0, diff8}, 64'd0);
        check("abort_borrow", {63'd0, borrow8}, 64'd0);
        check("abort_done", {63'd0, done8}, 64'd0);
        check("abort_busy", {63'd0, busy8}, 64'd0);
        rst = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", {63'd0, done8}, 64'd0);
            check("abort_idle", {63'd0, busy8}, 64'd0);
        end
        op8(8'd9, 8'd4, 8'h05, 1'b0);

        // start held high: one done every 9 cycles, busy low only then.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd10; b8 = 8'd1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            check("hold_done", {63'd0, done8}, {63'd0, (j % 9) == 8});
            check("hold_busy", {63'd0, busy8}, {63'd0, (j % 9) != 8});
            if ((j % 9) == 8) check("hold_diff", {56'd0, diff8}, 64'h09);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_drain_idle", {63'd0, busy8}, 64'd0);

        // WIDTH=1 boundary, all operand pairs.
        for (int i = 0; i < 4; i++) op1(i[1], i[0]);

        // WIDTH=32 directed plus a small random sample.
        op32(32'h0000_0000, 32'h0000_0001);
        op32(32'hFFFF_FFFF, 32'h0000_0000);
        op32(32'h8000_0000, 32'h7FFF_FFFF);
        op32(32'h1234_5678, 32'h1234_5678);
        for (int i = 0; i < 8; i++) op32($urandom, $urandom);

        // Random WIDTH=8 operands against the bench's reference subtraction.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] ra, rb;
            logic [8:0] e;
            ra = 8'($urandom);
            rb = 8'($urandom);
            e = {1'b0, ra} - {1'b0, rb};
            op8(ra, rb, e[7:0], e[8]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
